// File: rtl/acc_operand_stage.sv
// acc_operand_stage: operand fetch below the accumulator-control decoder.
// Holds the register file and accumulator and selects two operands by acc_ctrl.
// Registers the operands into a valid/ready slot for execute.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, acc_ctrl, ra1, ra2 : upstream instruction
//   wb_we/wb_addr/wb_data                 : register-file writeback
//   acc_we/acc_wdata                      : accumulator writeback
//   out_valid/out_ready, rd1, rd2, out_ctrl : execute slot
//   acc_q                                 : current accumulator
// Option: define ACC_OPERAND_BYPASS_EN so same-edge writebacks forward into reads.
module acc_operand_stage #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    acc_ctrl,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          acc_we,
    input  logic [DW-1:0] acc_wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [2:0]    out_ctrl,
    output logic [DW-1:0] acc_q
);

    localparam int NR = 1 << AW;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DW-1:0] rf [NR];
    logic [DW-1:0] acc;

    logic          accept;
    logic          drain;
    logic          is_mov;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] a;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign is_mov    = (acc_ctrl == 3'b101);
    assign acc_q     = acc;

`ifdef ACC_OPERAND_BYPASS_EN
    assign r1 = (wb_we && wb_addr == ra1) ? wb_data : rf[ra1];
    assign r2 = (wb_we && wb_addr == ra2) ? wb_data : rf[ra2];
    assign a  = acc_we ? acc_wdata : acc;
`else
    assign r1 = rf[ra1];
    assign r2 = rf[ra2];
    assign a  = acc;
`endif

    // Unlisted codes fall through to the register/register default.
    always_comb begin
        op1 = r1;
        op2 = r2;
        unique case (1'b1)
            (acc_ctrl == 3'b001),
            (acc_ctrl == 3'b101): op2 = a;
            (acc_ctrl == 3'b010): op1 = a;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1      <= '0;
            rd2      <= '0;
            out_ctrl <= '0;
        end else if (accept) begin
            rd1      <= op1;
            rd2      <= op2;
            out_ctrl <= acc_ctrl;
        end
    end

    // MOV is younger than the writeback, so its write is placed last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                rf[i] <= '0;
            end
            acc <= '0;
        end else begin
            if (wb_we) begin
                rf[wb_addr] <= wb_data;
            end
            if (accept && is_mov) begin
                rf[ra1] <= a;
            end
            if (acc_we) begin
                acc <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_acc_operand_stage.sv
// tb_acc_operand_stage: directed and random stimulus for acc_operand_stage.
// A behavioural model of the register file, accumulator and output slot is compared every cycle.
module tb_acc_operand_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] acc_ctrl;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       wb_we;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       acc_we;
    logic [7:0] acc_wdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [2:0] out_ctrl;
    logic [7:0] acc_q;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_rf [8];
    logic [7:0] m_acc;
    logic       m_valid;
    logic [7:0] m_rd1;
    logic [7:0] m_rd2;
    logic [2:0] m_ctrl;

    acc_operand_stage #(.DW(8), .AW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .acc_ctrl(acc_ctrl), .ra1(ra1), .ra2(ra2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .acc_we(acc_we), .acc_wdata(acc_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd1(rd1), .rd2(rd2), .out_ctrl(out_ctrl),
        .acc_q(acc_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_acc   = 8'h00;
        m_valid = 1'b0;
        m_rd1   = 8'h00;
        m_rd2   = 8'h00;
        m_ctrl  = 3'b000;
    endtask

    function automatic logic [7:0] reg_read(input logic [2:0] x);
`ifdef ACC_OPERAND_BYPASS_EN
        if (wb_we && wb_addr == x) return wb_data;
`endif
        return m_rf[x];
    endfunction

    function automatic logic [7:0] acc_read();
`ifdef ACC_OPERAND_BYPASS_EN
        if (acc_we) return acc_wdata;
`endif
        return m_acc;
    endfunction

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_step();
        logic       take;
        logic [7:0] o1, o2, av;
        if (reset) begin
            model_clear();
            return;
        end
        take = in_valid && (!m_valid || out_ready);
        av = acc_read();
        o1 = reg_read(ra1);
        o2 = reg_read(ra2);
        case (acc_ctrl)
            3'b001, 3'b101: o2 = av;
            3'b010:         o1 = av;
            default: ;
        endcase
        if (wb_we) m_rf[wb_addr] = wb_data;
        if (acc_we) m_acc = acc_wdata;
        if (take && acc_ctrl == 3'b101) m_rf[ra1] = av;
        if (take) begin
            m_valid = 1'b1;
            m_rd1   = o1;
            m_rd2   = o2;
            m_ctrl  = acc_ctrl;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cyc(input logic iv, input logic [2:0] c,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic orr,
                       input logic we, input logic [2:0] wa,
                       input logic [7:0] wd,
                       input logic awe, input logic [7:0] awd);
        in_valid  = iv;
        acc_ctrl  = c;
        ra1       = a1;
        ra2       = a2;
        out_ready = orr;
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        acc_we    = awe;
        acc_wdata = awd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(0, 3'b000, 3'd0, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        chk("acc_q", 32'(acc_q), 32'(m_acc));
        if (m_valid) begin
            chk("rd1", 32'(rd1), 32'(m_rd1));
            chk("rd2", 32'(rd2), 32'(m_rd2));
            chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
        end
    end

    initial begin
        logic [7:0] hz;
        reset = 1'b1;
        model_clear();
        in_valid = 0; acc_ctrl = 0; ra1 = 0; ra2 = 0;
        out_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
        acc_we = 0; acc_wdata = 0;
        @(posedge clk); model_step(); #1;
        @(posedge clk); model_step(); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rd1", 32'(rd1), 32'd0);
        chk("rst_acc_q", 32'(acc_q), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        cyc(0, 3'b000, 3'd0, 3'd0, 1, 1, 3'd3, 8'h5A, 1, 8'h11);
        cyc(1, 3'b000, 3'd3, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        chk("t000_rd1", 32'(rd1), 32'h5A);
        chk("t000_rd2", 32'(rd2), 32'h00);
        chk("t000_valid", 32'(out_valid), 32'd1);
        cyc(1, 3'b001, 3'd3, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        chk("t001_rd2", 32'(rd2), 32'h11);
        cyc(1, 3'b010, 3'd0, 3'd3, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        chk("t010_rd1", 32'(rd1), 32'h11);
        chk("t010_rd2", 32'(rd2), 32'h5A);
        cyc(1, 3'b110, 3'd3, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        chk("t110_rd1", 32'(rd1), 32'h5A);
        chk("t110_ctrl", 32'(out_ctrl), 32'b110);

        cyc(0, 3'b000, 3'd0, 3'd0, 1, 0, 3'd0, 8'h00, 1, 8'h77);
        cyc(1, 3'b101, 3'd6, 3'd0, 1, 1, 3'd6, 8'h22, 0, 8'h00);
        chk("mov_rd2", 32'(rd2), 32'h77);
        cyc(1, 3'b000, 3'd6, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        chk("mov_rf6", 32'(rd1), 32'h77);

        cyc(1, 3'b000, 3'd3, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'b000, 3'd6, 3'd0, 0, 0, 3'd0, 8'h00, 0, 8'h00);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_rd1", 32'(rd1), 32'h5A);
        end
        cyc(1, 3'b000, 3'd6, 3'd0, 1, 0, 3'd0, 8'h00, 0, 8'h00);
        chk("unstall_rd1", 32'(rd1), 32'h77);

        cyc(0, 3'b000, 3'd0, 3'd0, 1, 1, 3'd2, 8'h01, 0, 8'h00);
        cyc(1, 3'b000, 3'd2, 3'd0, 1, 1, 3'd2, 8'hC3, 0, 8'h00);
`ifdef ACC_OPERAND_BYPASS_EN
        hz = 8'hC3;
`else
        hz = 8'h01;
`endif
        chk("hazard_rd1", 32'(rd1), 32'(hz));

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                model_clear();
                @(posedge clk); model_step(); #1;
                reset = 1'b0;
            end else begin
                cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                    8'($urandom), $urandom_range(0, 3) == 0,
                    8'($urandom));
            end
        end

        cyc(0, 3'b000, 3'd0, 3'd0, 1, 1, 3'd5, 8'hAB, 1, 8'h3C);
        cyc(1, 3'b001, 3'd5, 3'd5, 0, 0, 3'd0, 8'h00, 0, 8'h00);
        cyc(1, 3'b000, 3'd1, 3'd1, 0, 0, 3'd0, 8'h00, 0, 8'h00);
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_acc", 32'(acc_q), 32'd0);
        @(posedge clk); model_step(); #1;
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            cyc(1, 3'b000, 3'(r), 3'(r), 1, 0, 3'd0, 8'h00, 0, 8'h00);
            chk("rst_rf", 32'({rd1, rd2}), 32'd0);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
